dnpcie_aurora_link_watchdog: RTL and testbench
==============================================

DNPCIE_AURORA_LINK_WATCHDOG -- requirements
Module: dnpcie_aurora_link_watchdog

Interface
REQ-001 SHALL have parameter MAX_RETRIES, default 7: consecutive failed link attempts before FAULT.
REQ-002 SHALL have parameter DROP_FILTER, default 1024: init_clk cycles channel_up must stay low before a drop counts.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 64: cycles allowed for reset_busy_i to rise after ext_reset_o asserts.
REQ-004 SHALL use one clock and a synchronous, active-low reset, exactly as follows:
- init_clk  input  1  sole clock.
- rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have these remaining ports:
- enable_i  input  1  watchdog enable.
- sw_reset_req_i  input  1  one-cycle software reset request.
- link_timeout_i  input  32  cycles allowed for link-up after reset completes; 0 = wait forever.
- channel_up_i  input  1  async Aurora channel_up.
- reset_busy_i  input  1  reset_busy from the Aurora reset block, init_clk domain.
- ext_reset_o  output  1  reset request to the Aurora reset block, registered.
- link_up_o  output  1  filtered link status.
- retry_count_o  output  8  consecutive failed attempts.
- fault_o  output  1  retries exhausted or ack lost.
- state_o  output  3  current FSM state.

Function
REQ-006 SHALL synchronize channel_up_i through a 2-flop ASYNC_REG chain before any use.
REQ-007 SHALL implement the FSM with these states and encodings: IDLE=0, WAIT_READY=1, WAIT_LINK=2, LINK_UP=3, REQUEST=4, FAULT=5.
REQ-008 IDLE SHALL go to WAIT_READY when enable_i=1.
REQ-009 WAIT_READY SHALL go to WAIT_LINK when reset_busy_i=0, loading the timeout counter with link_timeout_i.
REQ-010 WAIT_LINK SHALL go to LINK_UP when synchronized channel_up=1.
REQ-011 WAIT_LINK SHALL, on counter terminal count with link_timeout_i≠0, increment retry_count_o and go to REQUEST, or go to FAULT if the increment would exceed MAX_RETRIES.
REQ-012 On LINK_UP entry, the FSM SHALL clear retry_count_o to 0; while in LINK_UP, a drop counter SHALL count cycles of synchronized channel_up=0 and clear on any 1.
REQ-013 When the drop counter reaches DROP_FILTER, LINK_UP SHALL go to REQUEST; a glitch shorter than DROP_FILTER cycles SHALL cause no transition.
REQ-014 REQUEST SHALL assert ext_reset_o from entry+1 cycle until the cycle after reset_busy_i is sampled 1, then deassert and go to WAIT_READY.
REQ-015 If reset_busy_i stays 0 for ACK_TIMEOUT cycles in REQUEST, the FSM SHALL deassert ext_reset_o and go to FAULT.
REQ-016 FAULT SHALL hold fault_o=1 and ext_reset_o=0 until sw_reset_req_i or enable_i=0.
REQ-017 sw_reset_req_i in any state other than REQUEST SHALL clear retry_count_o and fault_o and go to REQUEST; in REQUEST it SHALL be ignored.
REQ-018 enable_i=0 SHALL send the FSM to IDLE next cycle from any state except REQUEST, which finishes its handshake first.
REQ-019 Outside REQUEST, ext_reset_o SHALL be 0.
REQ-020 sw_reset_req_i SHALL take priority over enable_i=0 when both occur in the same cycle.
REQ-021 link_up_o SHALL be 1 only in LINK_UP.
REQ-022 retry_count_o SHALL saturate at 255.
REQ-023 Comparisons SHALL be unsigned, and link_timeout_i SHALL be sampled only at WAIT_LINK load.

Reset
REQ-024 rst_n=0 SHALL force IDLE, ext_reset_o=0, link_up_o=0, fault_o=0, retry_count_o=0, state_o=0, all counters=0 and sync flops=0.
REQ-025 Reset mid-REQUEST SHALL drop ext_reset_o on the next edge; the Aurora reset block completes independently.

Structure
REQ-026 State encodings and the default parameter values SHALL live in shared package dnpcie_aurora_pkg.
REQ-027 The link timeout counter SHALL be an instance of dsp_counter_terminal_count with FIXED_TCOUNT="FALSE" and update_tcount_i at WAIT_READY exit.
REQ-028 The drop and ack counters SHALL be local fabric counters.

Verification
REQ-029 Bench SHALL cover: enable_i=1, reset_busy_i 1→0, channel_up_i=1 after 100 cycles -> LINK_UP, link_up_o=1, retry_count_o=0, ext_reset_o never asserted.
REQ-030 Bench SHALL cover: in LINK_UP, channel_up_i low for 1023 cycles then high -> stays LINK_UP; low for 1024 -> REQUEST, ext_reset_o=1.
REQ-031 Bench SHALL cover: link_timeout_i=500, channel_up_i never rises, reset model asserts busy 2 cycles after request -> 7 requests spaced ~500+handshake cycles, then fault_o=1 with retry_count_o=7.
REQ-032 Bench SHALL cover: REQUEST with reset_busy_i held 0 -> ext_reset_o high exactly 64 cycles, then fault_o=1.
REQ-033 Bench SHALL cover: in FAULT, sw_reset_req_i pulse -> fault_o=0, retry_count_o=0, ext_reset_o=1 next cycle+1.
REQ-034 Bench SHALL cover: rst_n=0 during REQUEST -> ext_reset_o=0 next edge, state_o=0.

Source files
------------

// File: rtl/dnpcie_aurora_pkg.sv
// Shared state encodings, default parameters and helpers for the Aurora link watchdog.
package dnpcie_aurora_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_LINK  = 3'd2,
    ST_LINK_UP    = 3'd3,
    ST_REQUEST    = 3'd4,
    ST_FAULT      = 3'd5
  } wd_state_e;

  localparam int DEF_MAX_RETRIES = 7;
  localparam int DEF_DROP_FILTER = 1024;
  localparam int DEF_ACK_TIMEOUT = 64;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dsp_counter_terminal_count.sv
// Free-running up-counter that flags the cycle it reaches its terminal count,
// with the terminal value either fixed at build time or reloaded at run time.
module dsp_counter_terminal_count #(
  parameter int               WIDTH        = 32,
  parameter string            FIXED_TCOUNT = "TRUE",
  parameter logic [WIDTH-1:0] TCOUNT       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             update_tcount_i,
  input  logic [WIDTH-1:0] tcount_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_tcount;

  generate
    if (FIXED_TCOUNT == "TRUE") begin : g_fixed
      assign w_tcount = TCOUNT;
    end else begin : g_runtime
      logic [WIDTH-1:0] r_tcount;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_tcount <= '0;
        end else if (update_tcount_i) begin
          r_tcount <= tcount_i;
        end
      end
      assign w_tcount = r_tcount;
    end
  endgenerate

  // A terminal-count update also restarts the count from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (update_tcount_i) begin
      r_count <= '0;
    end else if (ce_i) begin
      r_count <= (r_count == w_tcount) ? '0 : r_count + WIDTH'(1);
    end
  end

  assign tc_o = ce_i && (r_count == w_tcount);

endmodule

// File: rtl/dnpcie_aurora_link_watchdog.sv
// Aurora link watchdog: supervises channel_up, re-runs the Aurora reset block on
// link-up timeout or a sustained drop, and faults when retries or the ack run out.
module dnpcie_aurora_link_watchdog
  import dnpcie_aurora_pkg::*;
#(
  parameter int MAX_RETRIES = DEF_MAX_RETRIES,
  parameter int DROP_FILTER = DEF_DROP_FILTER,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        init_clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        sw_reset_req_i,
  input  logic [31:0] link_timeout_i,
  input  logic        channel_up_i,
  input  logic        reset_busy_i,
  output logic        ext_reset_o,
  output logic        link_up_o,
  output logic [7:0]  retry_count_o,
  output logic        fault_o,
  output logic [2:0]  state_o
);

  localparam int DROP_W = $clog2(DROP_FILTER + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DROP_W-1:0] DROP_LAST     = DROP_W'(DROP_FILTER - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST      = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [31:0]       MAX_RETRIES_U = MAX_RETRIES;

  (* ASYNC_REG = "TRUE" *) logic r_cu_meta;
  (* ASYNC_REG = "TRUE" *) logic r_cu_sync;

  wd_state_e         r_state;
  logic              r_ext_reset;
  logic              r_link_up;
  logic              r_fault;
  logic [7:0]        r_retry;
  logic [DROP_W-1:0] r_drop;
  logic [ACK_W-1:0]  r_ack;
  logic              r_tmo_zero;

  logic        w_wr_exit;
  logic        w_tmo_tc;
  logic [31:0] w_tmo_tcount;
  logic [8:0]  w_retry_inc;

  always_ff @(posedge init_clk) begin
    if (!rst_n) begin
      r_cu_meta <= 1'b0;
      r_cu_sync <= 1'b0;
    end else begin
      r_cu_meta <= channel_up_i;
      r_cu_sync <= r_cu_meta;
    end
  end

  // The link timer is armed on the same edge the FSM leaves WAIT_READY for WAIT_LINK.
  assign w_wr_exit    = (r_state == ST_WAIT_READY) && enable_i && !sw_reset_req_i && !reset_busy_i;
  assign w_tmo_tcount = link_timeout_i - 32'd1;
  assign w_retry_inc  = {1'b0, r_retry} + 9'd1;

  dsp_counter_terminal_count #(
    .WIDTH        (32),
    .FIXED_TCOUNT ("FALSE"),
    .TCOUNT       (32'd0)
  ) u_link_tmo (
    .clk             (init_clk),
    .rst_n           (rst_n),
    .ce_i            (r_state == ST_WAIT_LINK),
    .update_tcount_i (w_wr_exit),
    .tcount_i        (w_tmo_tcount),
    .tc_o            (w_tmo_tc)
  );

  // Registered outputs default low each cycle; branches that stay in or enter
  // the owning state re-assert them.
  always_ff @(posedge init_clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ext_reset <= 1'b0;
      r_link_up   <= 1'b0;
      r_fault     <= 1'b0;
      r_retry     <= '0;
      r_drop      <= '0;
      r_ack       <= '0;
      r_tmo_zero  <= 1'b0;
    end else begin
      r_ext_reset <= 1'b0;
      r_link_up   <= 1'b0;
      r_fault     <= 1'b0;
      r_drop      <= '0;
      r_ack       <= '0;
      if (sw_reset_req_i && (r_state != ST_REQUEST)) begin
        r_state <= ST_REQUEST;
        r_retry <= '0;
      end else if (!enable_i && (r_state != ST_REQUEST)) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT_READY;
          ST_WAIT_READY: begin
            if (!reset_busy_i) begin
              r_state    <= ST_WAIT_LINK;
              r_tmo_zero <= (link_timeout_i == 32'd0);
            end
          end
          ST_WAIT_LINK: begin
            if (r_cu_sync) begin
              r_state   <= ST_LINK_UP;
              r_retry   <= '0;
              r_link_up <= 1'b1;
            end else if (!r_tmo_zero && w_tmo_tc) begin
              if ({23'd0, w_retry_inc} > MAX_RETRIES_U) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state <= ST_REQUEST;
                r_retry <= sat_inc8(r_retry);
              end
            end
          end
          ST_LINK_UP: begin
            if (r_cu_sync) begin
              r_link_up <= 1'b1;
            end else if (r_drop == DROP_LAST) begin
              r_state <= ST_REQUEST;
            end else begin
              r_drop    <= r_drop + DROP_W'(1);
              r_link_up <= 1'b1;
            end
          end
          ST_REQUEST: begin
            // ext_reset low here means this is the entry cycle.
            if (!r_ext_reset) begin
              r_ext_reset <= 1'b1;
            end else if (reset_busy_i) begin
              r_state <= ST_WAIT_READY;
            end else if (r_ack == ACK_LAST) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_ack       <= r_ack + ACK_W'(1);
              r_ext_reset <= 1'b1;
            end
          end
          ST_FAULT: r_fault <= 1'b1;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ext_reset_o   = r_ext_reset;
  assign link_up_o     = r_link_up;
  assign fault_o       = r_fault;
  assign retry_count_o = r_retry;
  assign state_o       = r_state;

endmodule

// File: tb/tb_dnpcie_aurora_link_watchdog.sv
// Bench for the Aurora link watchdog: directed scenarios plus a randomized run,
// checked every cycle against a time-in-state behavioural model.
module tb_dnpcie_aurora_link_watchdog;

  localparam int MAXR = 7;
  localparam int DROP = 1024;
  localparam int ACK  = 64;
  localparam int S_IDLE = 0, S_WR = 1, S_WL = 2, S_LU = 3, S_REQ = 4, S_FAULT = 5;

  logic        init_clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        sw_reset_req_i;
  logic [31:0] link_timeout_i;
  logic        channel_up_i;
  logic        reset_busy_i;
  logic        ext_reset_o;
  logic        link_up_o;
  logic [7:0]  retry_count_o;
  logic        fault_o;
  logic [2:0]  state_o;

  logic busy_manual = 1'b0;
  logic bfm_en      = 1'b0;
  logic bfm_busy    = 1'b0;
  assign reset_busy_i = bfm_en ? bfm_busy : busy_manual;

  always #5 init_clk = ~init_clk;

  dnpcie_aurora_link_watchdog #(
    .MAX_RETRIES (MAXR),
    .DROP_FILTER (DROP),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .init_clk       (init_clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .sw_reset_req_i (sw_reset_req_i),
    .link_timeout_i (link_timeout_i),
    .channel_up_i   (channel_up_i),
    .reset_busy_i   (reset_busy_i),
    .ext_reset_o    (ext_reset_o),
    .link_up_o      (link_up_o),
    .retry_count_o  (retry_count_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  // Reset-block stand-in: busy rises two cycles after ext_reset is seen, holds a few cycles.
  int b_phase = 0;
  int b_cnt   = 0;
  always @(negedge init_clk) begin
    if (!bfm_en) begin
      bfm_busy = 1'b0;
      b_phase  = 0;
      b_cnt    = 0;
    end else begin
      case (b_phase)
        0: if (ext_reset_o === 1'b1) begin b_phase = 1; b_cnt = 1; end
        1: begin
          b_cnt++;
          if (b_cnt == 2) begin bfm_busy = 1'b1; b_phase = 2; b_cnt = 0; end
        end
        default: begin
          b_cnt++;
          if (b_cnt == 5) begin bfm_busy = 1'b0; b_phase = 0; end
        end
      endcase
    end
  end

  // Behavioural model: state plus elapsed cycles in it, consecutive low run, latched timeout.
  int      m_state   = S_IDLE;
  longint  m_t       = 0;
  int      m_low     = 0;
  int      m_retry   = 0;
  longint  m_timeout = 0;
  bit      h1 = 1'b0, h2 = 1'b0;
  int      m_ns;
  bit      m_cu;

  always @(posedge init_clk) begin
    m_cu = h2;
    h2   = h1;
    h1   = channel_up_i;
    if (!rst_n) begin
      m_state = S_IDLE; m_t = 0; m_low = 0; m_retry = 0; m_timeout = 0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      m_ns = m_state;
      if (sw_reset_req_i && m_state != S_REQ) begin
        m_ns = S_REQ;
        m_retry = 0;
      end else if (!enable_i && m_state != S_REQ) begin
        m_ns = S_IDLE;
      end else begin
        case (m_state)
          S_IDLE: m_ns = S_WR;
          S_WR: if (!reset_busy_i) begin m_ns = S_WL; m_timeout = longint'(link_timeout_i); end
          S_WL: begin
            if (m_cu) begin
              m_ns = S_LU; m_retry = 0;
            end else if (m_timeout != 0 && m_t + 1 == m_timeout) begin
              if (m_retry + 1 > MAXR) m_ns = S_FAULT;
              else begin m_ns = S_REQ; m_retry = (m_retry < 255) ? m_retry + 1 : 255; end
            end
          end
          S_LU: begin
            if (m_cu) m_low = 0; else m_low++;
            if (m_low == DROP) m_ns = S_REQ;
          end
          S_REQ: begin
            if (m_t == 0) m_ns = S_REQ;
            else if (reset_busy_i) m_ns = S_WR;
            else if (m_t == ACK) m_ns = S_FAULT;
          end
          default: m_ns = m_state;
        endcase
      end
      if (m_ns != m_state) begin m_t = 0; m_low = 0; end
      else m_t++;
      m_state = m_ns;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ext_cycles = 0;
  bit chk_en = 1'b0;

  task automatic tick();
    logic e_ext, e_link, e_fault;
    @(negedge init_clk);
    cyc++;
    if (ext_reset_o === 1'b1) ext_cycles++;
    if (chk_en) begin
      e_ext   = (m_state == S_REQ) && (m_t >= 1);
      e_link  = (m_state == S_LU);
      e_fault = (m_state == S_FAULT);
      n_cmp++;
      if (state_o !== 3'(m_state) || ext_reset_o !== e_ext || link_up_o !== e_link ||
          fault_o !== e_fault || retry_count_o !== 8'(m_retry)) begin
        n_bad++;
        if (n_bad <= 30)
          $display("FAIL model_cycle %0d: state %0d/%0d ext %b/%b link %b/%b fault %b/%b retry %0d/%0d (got/expected)",
                   cyc, state_o, m_state, ext_reset_o, e_ext, link_up_o, e_link, fault_o, e_fault,
                   retry_count_o, m_retry);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int k, n, e0, nreq, last, sp_bad, run, dis;
  bit prev_ext;

  initial begin
    rst_n = 1'b0; enable_i = 1'b0; sw_reset_req_i = 1'b0; link_timeout_i = 32'd0; channel_up_i = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ext", 32'(ext_reset_o), 0);
    chk("rst_link", 32'(link_up_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_retry", 32'(retry_count_o), 0);

    // Clean bring-up
    rst_n = 1'b1; busy_manual = 1'b1; enable_i = 1'b1; e0 = ext_cycles;
    repeat (10) tick();
    chk("s1_wait_ready", 32'(state_o), 1);
    busy_manual = 1'b0;
    repeat (100) tick();
    chk("s1_wait_link", 32'(state_o), 2);
    channel_up_i = 1'b1; k = 0;
    while (link_up_o !== 1'b1 && k < 50) begin tick(); k++; end
    chk("s1_link_latency", 32'(k), 3);
    chk("s1_state", 32'(state_o), 3);
    chk("s1_retry", 32'(retry_count_o), 0);
    chk("s1_no_ext", 32'(ext_cycles - e0), 0);

    // Drop filter boundary
    channel_up_i = 1'b0;
    repeat (1023) tick();
    channel_up_i = 1'b1;
    repeat (5) tick();
    chk("s2_glitch1023_state", 32'(state_o), 3);
    chk("s2_glitch1023_link", 32'(link_up_o), 1);
    channel_up_i = 1'b0; k = 0;
    while (state_o !== 3'd4 && k < 1200) begin tick(); k++; end
    chk("s2_drop_latency", 32'(k), 1026);
    chk("s2_entry_ext", 32'(ext_reset_o), 0);
    tick();
    chk("s2_ext_asserted", 32'(ext_reset_o), 1);

    // Ack lost: busy never rises
    n = 0;
    while (ext_reset_o === 1'b1 && n < 200) begin n++; tick(); end
    chk("s4_ext_high_cycles", 32'(n), 64);
    chk("s4_fault", 32'(fault_o), 1);
    chk("s4_state", 32'(state_o), 5);
    enable_i = 1'b0;
    tick();
    chk("dis_fault_clear", 32'(fault_o), 0);
    chk("dis_state", 32'(state_o), 0);

    // Retry exhaustion with a responsive reset block
    bfm_en = 1'b1; link_timeout_i = 32'd500; enable_i = 1'b1;
    nreq = 0; last = 0; sp_bad = 0; prev_ext = 1'b0; k = 0;
    while (fault_o !== 1'b1 && k < 6000) begin
      tick(); k++;
      if (ext_reset_o === 1'b1 && !prev_ext) begin
        nreq++;
        if (nreq > 1 && cyc - last != 508) sp_bad++;
        last = cyc;
      end
      prev_ext = ext_reset_o;
    end
    chk("s3_requests", 32'(nreq), 7);
    chk("s3_spacing_errs", 32'(sp_bad), 0);
    chk("s3_fault_delay", 32'(cyc - last), 507);
    chk("s3_fault", 32'(fault_o), 1);
    chk("s3_retry", 32'(retry_count_o), 7);

    // Software reset out of FAULT, then hard reset mid-handshake
    bfm_en = 1'b0; busy_manual = 1'b0;
    sw_reset_req_i = 1'b1;
    tick();
    sw_reset_req_i = 1'b0;
    chk("s5_fault", 32'(fault_o), 0);
    chk("s5_retry", 32'(retry_count_o), 0);
    chk("s5_state", 32'(state_o), 4);
    chk("s5_ext_entry", 32'(ext_reset_o), 0);
    tick();
    chk("s5_ext", 32'(ext_reset_o), 1);
    rst_n = 1'b0;
    tick();
    chk("s6_ext", 32'(ext_reset_o), 0);
    chk("s6_state", 32'(state_o), 0);
    rst_n = 1'b1;

    // Randomized run
    bfm_en = 1'b1; run = 0; dis = 0; link_timeout_i = 32'd200;
    for (int i = 0; i < 9000; i++) begin
      if (run == 0) begin channel_up_i = ~channel_up_i; run = $urandom_range(1, 1400); end
      run--;
      sw_reset_req_i = ($urandom_range(0, 399) == 0);
      if (dis > 0) begin enable_i = 1'b0; dis--; end
      else begin enable_i = 1'b1; if ($urandom_range(0, 699) == 0) dis = $urandom_range(1, 6); end
      if ($urandom_range(0, 99) == 0) link_timeout_i = $urandom_range(0, 300);
      if ($urandom_range(0, 1999) == 0) bfm_en = ~bfm_en;
      rst_n = ($urandom_range(0, 2999) != 0);
      tick();
    end
    rst_n = 1'b1; sw_reset_req_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
